// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: aligns and issues one data-memory access per instruction,
// stalls the pipeline until ack or timeout, then returns the extended load result.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [5:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                           OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t         state_reg, state_next;
    logic [5:0]     op_reg;
    logic [1:0]     lane_reg;
    logic           we_reg;
    logic           berr_reg;
    logic [CW-1:0]  cnt_reg;

    logic        is_load, is_store, is_mem, is_byte, is_half, aligned, accept, timeout_hit;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, ext_data;

    always_comb begin
        is_load  = (ex_op == OP_LB) || (ex_op == OP_LH) || (ex_op == OP_LW) ||
                   (ex_op == OP_LBU) || (ex_op == OP_LHU);
        is_store = (ex_op == OP_SB) || (ex_op == OP_SH) || (ex_op == OP_SW);
        is_mem   = is_load || is_store;
        // Size lives in op[1:0] for every memory opcode: 00 byte, 01 half, 11 word.
        is_byte  = (ex_op[1:0] == 2'b00);
        is_half  = (ex_op[1:0] == 2'b01);
        if (is_byte)      aligned = 1'b1;
        else if (is_half) aligned = ~ex_addr[0];
        else              aligned = (ex_addr[1:0] == 2'b00);

        if (is_byte) begin
            be_new    = 4'b0001 << ex_addr[1:0];
            wdata_new = {4{ex_wdata[7:0]}};
        end else if (is_half) begin
            be_new    = ex_addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{ex_wdata[15:0]}};
        end else begin
            be_new    = 4'b1111;
            wdata_new = ex_wdata;
        end

        accept      = (state_reg == IDLE) && ex_valid && is_mem && aligned;
        addr_err    = (state_reg == IDLE) && ex_valid && is_mem && !aligned;
        timeout_hit = (cnt_reg == LAST_CNT);
    end

    always_comb begin
        ext_data = mem_rdata;
        case (op_reg)
            OP_LB:  ext_data = {{24{mem_rdata[8*lane_reg+7]}}, mem_rdata[8*lane_reg +: 8]};
            OP_LBU: ext_data = {24'd0, mem_rdata[8*lane_reg +: 8]};
            OP_LH:  ext_data = lane_reg[1] ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                           : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            OP_LHU: ext_data = lane_reg[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        mem_req    = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = accept;
                if (accept) state_next = REQ;
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || timeout_hit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        mem_we  = mem_req && we_reg;
        bus_err = done && berr_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= 6'd0;
            lane_reg  <= 2'd0;
            we_reg    <= 1'b0;
            berr_reg  <= 1'b0;
            cnt_reg   <= '0;
            load_data <= 32'd0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg    <= ex_op;
                lane_reg  <= ex_addr[1:0];
                we_reg    <= is_store;
                berr_reg  <= 1'b0;
                cnt_reg   <= '0;
                mem_addr  <= {ex_addr[31:2], 2'b00};
                mem_be    <= be_new;
                mem_wdata <= wdata_new;
            end else if (state_reg == REQ) begin
                if (mem_ack) begin
                    if (!we_reg) load_data <= ext_data;
                end else if (timeout_hit) begin
                    berr_reg  <= 1'b1;
                    load_data <= 32'd0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads/stores with hand-computed results,
// misalignment, timeout and reset during an outstanding request.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [5:0]  ex_op = 6'd0;
    logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
    logic        stall, done, addr_err, bus_err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYC(255)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .stall(stall), .done(done), .load_data(load_data),
        .addr_err(addr_err), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Observed results of one access (filled by do_access, judged by the calling test).
    int          o_stall, o_req;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_ld;
    logic        o_we, o_done, o_berr;

    // Issue one instruction and act as memory: ack after ack_wait non-ack REQ cycles (-1 = never).
    task automatic do_access(input logic [5:0] op, input logic [31:0] addr, wdata, rdata,
                             input int ack_wait);
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wdata; mem_rdata = rdata;
        o_stall = 0; o_req = 0; o_done = 1'b0; o_we = 1'b0; o_berr = 1'b0;
        o_be = 4'd0; o_addr = 32'd0; o_wdata = 32'd0; o_ld = 32'hxxxx_xxxx;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc >= 1) ex_valid = 1'b0;
            if (stall) o_stall++;
            if (mem_req) begin
                o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
                mem_ack = (ack_wait >= 0) && (o_req == ack_wait);
                o_req++;
            end else begin
                mem_ack = 1'b0;
            end
            if (done) begin
                o_done = 1'b1; o_ld = load_data; o_berr = bus_err;
                break;
            end
        end
        mem_ack = 1'b0; ex_valid = 1'b0;
        tests++;
        if (o_done !== 1'b1) begin
            fails++; $display("FAIL done_timeout op=%h addr=%h: no done pulse within budget", op, addr);
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({stall, done, mem_req, mem_we, bus_err, addr_err} !== 6'b0 || load_data !== 0 ||
            mem_be !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            fails++;
            $display("FAIL reset: stall=%b done=%b req=%b we=%b berr=%b ld=%h be=%b addr=%h wd=%h required all zero",
                     stall, done, mem_req, mem_we, bus_err, load_data, mem_be, mem_addr, mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_lb_sign();
        do_access(6'h20, 32'h103, 32'h0, 32'h80FF_FFFF, 0);
        tests++;
        if (o_be !== 4'b1000 || o_addr !== 32'h100 || o_stall !== 2 || o_ld !== 32'hFFFF_FF80 || o_we !== 1'b0) begin
            fails++;
            $display("FAIL lb_sign: be=%b addr=%h stall=%0d ld=%h we=%b required 1000 100 2 ffffff80 0",
                     o_be, o_addr, o_stall, o_ld, o_we);
        end
        $display("[TB] LB 0x103 -> ld=%h stall=%0d", o_ld, o_stall);
    endtask

    task automatic test_lhu_wait();
        do_access(6'h25, 32'h202, 32'h0, 32'h8001_1234, 3);
        tests++;
        if (o_be !== 4'b1100 || o_stall !== 5 || o_ld !== 32'h0000_8001 || o_berr !== 1'b0) begin
            fails++;
            $display("FAIL lhu_wait: be=%b stall=%0d ld=%h berr=%b required 1100 5 00008001 0",
                     o_be, o_stall, o_ld, o_berr);
        end
        $display("[TB] LHU 0x202 -> ld=%h stall=%0d", o_ld, o_stall);
    endtask

    task automatic test_store_half();
        do_access(6'h29, 32'h10, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        tests++;
        if (o_we !== 1'b1 || o_be !== 4'b0011 || o_wdata !== 32'hBEEF_BEEF || o_ld !== 32'h0000_8001) begin
            fails++;
            $display("FAIL store_half: we=%b be=%b wd=%h ld=%h required 1 0011 beefbeef 00008001",
                     o_we, o_be, o_wdata, o_ld);
        end
        $display("[TB] SH 0x10 -> wd=%h be=%b", o_wdata, o_be);
    endtask

    task automatic test_other_ops();
        do_access(6'h21, 32'h0, 32'h0, 32'h0000_F234, 0);      // LH sign from low half
        tests++;
        if (o_be !== 4'b0011 || o_ld !== 32'hFFFF_F234) begin
            fails++; $display("FAIL lh_sign: be=%b ld=%h required 0011 fffff234", o_be, o_ld);
        end
        do_access(6'h24, 32'h1, 32'h0, 32'h0000_9A00, 1);      // LBU lane 1
        tests++;
        if (o_be !== 4'b0010 || o_ld !== 32'h0000_009A || o_stall !== 3) begin
            fails++; $display("FAIL lbu: be=%b ld=%h stall=%0d required 0010 0000009a 3", o_be, o_ld, o_stall);
        end
        do_access(6'h23, 32'h24, 32'h0, 32'hCAFE_F00D, 0);     // LW
        tests++;
        if (o_be !== 4'b1111 || o_addr !== 32'h24 || o_ld !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL lw: be=%b addr=%h ld=%h required 1111 24 cafef00d", o_be, o_addr, o_ld);
        end
        do_access(6'h28, 32'h2, 32'h0000_005A, 32'h0, 0);      // SB lane 2
        tests++;
        if (o_be !== 4'b0100 || o_wdata !== 32'h5A5A_5A5A || o_we !== 1'b1 || o_ld !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL sb: be=%b wd=%h we=%b ld=%h required 0100 5a5a5a5a 1 cafef00d",
                              o_be, o_wdata, o_we, o_ld);
        end
        do_access(6'h2B, 32'h7C, 32'h0123_4567, 32'h0, 0);     // SW
        tests++;
        if (o_be !== 4'b1111 || o_wdata !== 32'h0123_4567 || o_addr !== 32'h7C) begin
            fails++; $display("FAIL sw: be=%b wd=%h addr=%h required 1111 01234567 7c", o_be, o_wdata, o_addr);
        end
        $display("[TB] LH/LBU/LW/SB/SW sequence complete");
    endtask

    task automatic test_misaligned();
        logic [5:0]  ops [3] = '{6'h23, 6'h21, 6'h2B};
        logic [31:0] adr [3] = '{32'h06, 32'h03, 32'h01};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ex_valid = 1'b1; ex_op = ops[i]; ex_addr = adr[i];
            @(negedge clk);
            tests++;
            if (addr_err !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
                fails++; $display("FAIL misaligned_%0d: addr_err=%b stall=%b req=%b required 1 0 0",
                                  i, addr_err, stall, mem_req);
            end
            @(posedge clk); #1; ex_valid = 1'b0;
            @(negedge clk);
            tests++;
            if (addr_err !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0) begin
                fails++; $display("FAIL misaligned_after_%0d: addr_err=%b req=%b stall=%b required 0 0 0",
                                  i, addr_err, mem_req, stall);
            end
        end
        // Non-memory opcode with valid set must be ignored.
        @(posedge clk); #1; ex_valid = 1'b1; ex_op = 6'h00; ex_addr = 32'h3;
        @(negedge clk);
        tests++;
        if (addr_err !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL non_mem_op: addr_err=%b stall=%b required 0 0", addr_err, stall);
        end
        @(posedge clk); #1; ex_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL non_mem_req: req=%b required 0", mem_req);
        end
        $display("[TB] misaligned / non-memory ops checked");
    endtask

    task automatic test_timeout();
        do_access(6'h23, 32'h40, 32'h0, 32'hFFFF_FFFF, -1);
        tests++;
        if (o_req !== 255 || o_berr !== 1'b1 || o_ld !== 32'h0) begin
            fails++; $display("FAIL timeout: req_cycles=%0d berr=%b ld=%h required 255 1 00000000",
                              o_req, o_berr, o_ld);
        end
        @(negedge clk);
        tests++;
        if (bus_err !== 1'b0 || done !== 1'b0 || load_data !== 32'h0) begin
            fails++; $display("FAIL timeout_after: berr=%b done=%b ld=%h required 0 0 0", bus_err, done, load_data);
        end
        $display("[TB] LW timeout -> req_cycles=%0d berr=%b", o_req, o_berr);
    endtask

    task automatic test_back_to_back();
        do_access(6'h23, 32'h80, 32'h0, 32'h1111_2222, 0);
        do_access(6'h24, 32'h83, 32'h0, 32'hF700_0000, 0);
        tests++;
        if (o_ld !== 32'h0000_00F7 || o_stall !== 2 || o_be !== 4'b1000) begin
            fails++; $display("FAIL back_to_back: ld=%h stall=%0d be=%b required 000000f7 2 1000",
                              o_ld, o_stall, o_be);
        end
        $display("[TB] back-to-back LW/LBU -> ld=%h", o_ld);
    endtask

    task automatic test_reset_mid_req();
        int seen_done = 0;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_op = 6'h23; ex_addr = 32'h40;
        @(posedge clk); #1; ex_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1) begin
            fails++; $display("FAIL rst_mid_setup: req=%b required 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0 || mem_addr !== 32'h0) begin
            fails++; $display("FAIL rst_mid_async: req=%b stall=%b ld=%h addr=%h required 0 0 0 0",
                              mem_req, stall, load_data, mem_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || mem_req) seen_done++;
        end
        tests++;
        if (seen_done !== 0) begin
            fails++; $display("FAIL rst_mid_nodone: done/req cycles=%0d required 0", seen_done);
        end
        $display("[TB] reset during REQ checked");
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_lhu_wait();
        test_store_half();
        test_other_ops();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: max cycles mem_req waits for mem_ack before bus error.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ex_valid  in  1  MEM-stage instruction valid.
REQ-005 ex_op  in  6  MIPS opcode; memory ops: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
REQ-006 ex_addr  in  32  effective byte address.
REQ-007 ex_wdata  in  32  store data (rt value).
REQ-008 stall  out  1  freeze IF..MEM pipeline registers.
REQ-009 done  out  1  one-cycle pulse: access complete, load_data valid.
REQ-010 load_data  out  32  sign/zero-extended load result.
REQ-011 addr_err  out  1  misaligned access flag.
REQ-012 bus_err  out  1  timeout flag, valid with done.
REQ-013 mem_req, mem_we  out  1 each  request / write strobe to data memory.
REQ-014 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-015 mem_be  out  4  byte enables, bit k = byte lane k (little-endian).
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_ack  in  1, mem_rdata  in  32  memory completion and read data.

Function
REQ-018 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-019 IDLE accept: ex_valid & memory op & aligned -> latch op, addr, be, wdata; go REQ; stall=1 same cycle.
REQ-020 Alignment: word needs addr[1:0]=00, half needs addr[0]=0, byte always aligned.
REQ-021 IDLE, ex_valid & memory op & misaligned -> addr_err=1 combinationally that cycle, stall=0, no request, stay IDLE.
REQ-022 IDLE, non-memory op or ex_valid=0 -> stall=0, no action.
REQ-023 be: byte 4'b0001<<addr[1:0]; half 4'b0011 (addr[1]=0) or 4'b1100; word 4'b1111.
REQ-024 mem_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-025 REQ: mem_req=1, mem_we=1 for stores, mem_addr/mem_be/mem_wdata registered and stable until ack; stall=1.
REQ-026 REQ, mem_ack=1 -> capture extended mem_rdata into load_data (loads only), go DONE; mem_req drops next cycle.
REQ-027 mem_ack while mem_req=0 ignored.
REQ-028 Extension: LB/LBU select lane by addr[1:0]; LH/LHU select [15:0] or [31:16] by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW pass-through.
REQ-029 Wait counter 8-bit min. width, cleared on REQ entry, incremented each REQ cycle without ack; at count = TIMEOUT_CYC-1 without ack -> go DONE with bus_err=1, load_data=0.
REQ-030 DONE: done=1, stall=0, one cycle, then IDLE unconditionally; next IDLE cycle treats inputs as a new instruction.
REQ-031 Stores: load_data unchanged; done still pulses.
REQ-032 Minimum latency: accept cycle, one REQ cycle with ack, DONE -> stall 2 cycles, done in 3rd.
REQ-033 load_data holds last value outside DONE.

Reset
REQ-034 rst_n=0 asynchronously forces IDLE, counter 0, load_data 0, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, done 0, bus_err 0.
REQ-035 Reset during REQ drops mem_req immediately; outstanding access abandoned, no done.

Verification
REQ-036 LB addr 0x103, mem_rdata 0x80FF_FFFF, ack in first REQ cycle -> mem_be 1000, mem_addr 0x100, stall 2 cycles, done with load_data 0xFFFF_FF80.
REQ-037 LHU addr 0x202, mem_rdata 0x8001_1234, ack after 3 wait cycles -> mem_be 1100, stall 5 cycles, load_data 0x0000_8001.
REQ-038 SH addr 0x10, ex_wdata 0xDEAD_BEEF -> mem_we 1, mem_be 0011, mem_wdata 0xBEEF_BEEF, load_data unchanged.
REQ-039 LW addr 0x06 -> addr_err 1 one cycle, stall 0, mem_req never asserted.
REQ-040 LW, mem_ack held 0 -> mem_req high TIMEOUT_CYC cycles, then done with bus_err 1, load_data 0.
REQ-041 rst_n low mid-REQ -> mem_req 0 without clock edge, state IDLE, no done pulse.
